// File: rtl/drive_cmd_arbiter_pkg.sv
// Shared types and helpers for the motor drive command arbiter.
// Drive codes, ownership/FSM encoding and direction-family predicates.
package drive_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    CmdStop      = 3'd0,
    CmdFastLeft  = 3'd1,
    CmdLeft      = 3'd2,
    CmdStraight  = 3'd3,
    CmdRight     = 3'd4,
    CmdFastRight = 3'd5
  } drive_cmd_t;

  // Encoding doubles as the FSM state and the owner debug output.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIr   = 2'd1,
    OwnVis  = 2'd2,
    OwnDead = 2'd3
  } owner_t;

  function automatic drive_cmd_t sanitize(input logic [2:0] code);
    return (code > 3'd5) ? CmdStop : drive_cmd_t'(code);
  endfunction

  function automatic logic is_left(input drive_cmd_t cmd);
    return (cmd == CmdFastLeft) || (cmd == CmdLeft);
  endfunction

  function automatic logic is_right(input drive_cmd_t cmd);
    return (cmd == CmdRight) || (cmd == CmdFastRight);
  endfunction

  function automatic logic is_reversal(input drive_cmd_t a, input drive_cmd_t b);
    return (is_left(a) && is_right(b)) || (is_right(a) && is_left(b));
  endfunction

endpackage

// File: rtl/drive_cmd_arbiter_out_stage.sv
// Valid/ready output slice: issues the current target whenever it differs from
// the last issued command and nothing is pending; the latest target always wins.
module drive_cmd_arbiter_out_stage
  import drive_cmd_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  drive_cmd_t i_target,
  input  logic       i_ready,
  output logic       o_valid,
  output drive_cmd_t o_cmd,
  output drive_cmd_t o_last_sent
);

  logic       r_valid;
  drive_cmd_t r_cmd;

  // Target is sampled only at issue time, so intermediate targets are dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_cmd   <= CmdStop;
    end else if (r_valid) begin
      if (i_ready) r_valid <= 1'b0;
    end else if (i_target != r_cmd) begin
      r_valid <= 1'b1;
      r_cmd   <= i_target;
    end
  end

  assign o_valid     = r_valid;
  assign o_cmd       = r_cmd;
  assign o_last_sent = r_cmd;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Arbitrates the motor drive between IR remote and audio-armed vision tracking,
// inserting a Stop dead time on left/right reversals.
module drive_cmd_arbiter
  import drive_cmd_arbiter_pkg::*;
#(
  parameter int unsigned IR_HOLD     = 1000,
  parameter int unsigned VIS_TIMEOUT = 500,
  parameter int unsigned DEADTIME    = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ir_valid,
  input  logic [2:0] i_ir_cmd,
  input  logic       i_vis_valid,
  input  logic [2:0] i_vis_cmd,
  input  logic       i_audio_arm,
  input  logic       i_out_ready,
  output logic       o_out_valid,
  output logic [2:0] o_out_cmd,
  output logic [1:0] o_owner
);

  localparam int unsigned MaxIv  = (IR_HOLD > VIS_TIMEOUT) ? IR_HOLD : VIS_TIMEOUT;
  localparam int unsigned MaxAll = (MaxIv > DEADTIME) ? MaxIv : DEADTIME;
  localparam int          CntW   = $clog2(MaxAll) + 1;

  localparam logic [CntW-1:0] IrHoldC = CntW'(IR_HOLD);
  localparam logic [CntW-1:0] VisToC  = CntW'(VIS_TIMEOUT);
  localparam logic [CntW-1:0] DeadC   = CntW'(DEADTIME);
  localparam logic [CntW-1:0] OneC    = CntW'(1);

  owner_t          r_state, w_state_nxt;
  owner_t          r_saved, w_saved_nxt;
  drive_cmd_t      r_ir_cmd, w_ir_cmd_nxt;
  drive_cmd_t      r_vis_cmd, w_vis_cmd_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [CntW-1:0] r_dead_cnt, w_dead_cnt_nxt;

  drive_cmd_t w_ir_cmd_s, w_vis_cmd_s;
  drive_cmd_t w_tgt_raw, w_tgt, w_last_sent, w_out_cmd;
  logic       w_rev;

  assign w_ir_cmd_s  = sanitize(i_ir_cmd);
  assign w_vis_cmd_s = sanitize(i_vis_cmd);

  always_comb begin
    w_tgt_raw = CmdStop;
    unique case (r_state)
      OwnIr:   w_tgt_raw = r_ir_cmd;
      OwnVis:  w_tgt_raw = (r_cnt == '0) ? CmdStop : r_vis_cmd;
      OwnNone: w_tgt_raw = CmdStop;
      OwnDead: w_tgt_raw = CmdStop;
    endcase
  end

  // A reversal holds Stop on the output this cycle and diverts the FSM into dead time.
  assign w_rev = ((r_state == OwnIr) || (r_state == OwnVis)) &&
                 is_reversal(w_tgt_raw, w_last_sent);
  assign w_tgt = w_rev ? CmdStop : w_tgt_raw;

  always_comb begin
    w_state_nxt    = r_state;
    w_saved_nxt    = r_saved;
    w_ir_cmd_nxt   = r_ir_cmd;
    w_vis_cmd_nxt  = r_vis_cmd;
    w_cnt_nxt      = r_cnt;
    w_dead_cnt_nxt = r_dead_cnt;
    unique case (r_state)
      OwnNone: begin
        if (i_ir_valid) begin
          w_state_nxt  = OwnIr;
          w_ir_cmd_nxt = w_ir_cmd_s;
          w_cnt_nxt    = IrHoldC;
        end else if (i_vis_valid && i_audio_arm) begin
          w_state_nxt   = OwnVis;
          w_vis_cmd_nxt = w_vis_cmd_s;
          w_cnt_nxt     = VisToC;
        end
      end
      OwnIr: begin
        if (i_ir_valid) begin
          w_ir_cmd_nxt = w_ir_cmd_s;
          w_cnt_nxt    = IrHoldC;
        end
        if (w_rev) begin
          w_state_nxt    = OwnDead;
          w_saved_nxt    = OwnIr;
          w_dead_cnt_nxt = DeadC;
        end else if (!i_ir_valid) begin
          if (r_cnt <= OneC) begin
            w_state_nxt = OwnNone;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - OneC;
          end
        end
      end
      OwnVis: begin
        if (i_ir_valid) begin
          w_state_nxt  = OwnIr;
          w_ir_cmd_nxt = w_ir_cmd_s;
          w_cnt_nxt    = IrHoldC;
        end else if (!i_audio_arm) begin
          w_state_nxt = OwnNone;
          w_cnt_nxt   = '0;
        end else begin
          if (i_vis_valid) begin
            w_vis_cmd_nxt = w_vis_cmd_s;
            w_cnt_nxt     = VisToC;
          end else if (!w_rev && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - OneC;
          end
          if (w_rev) begin
            w_state_nxt    = OwnDead;
            w_saved_nxt    = OwnVis;
            w_dead_cnt_nxt = DeadC;
          end
        end
      end
      OwnDead: begin
        // IR still steers the post-dead-time target without extending the dead time.
        if (i_ir_valid) begin
          w_ir_cmd_nxt = w_ir_cmd_s;
          w_cnt_nxt    = IrHoldC;
          w_saved_nxt  = OwnIr;
        end
        if (r_dead_cnt <= OneC) begin
          w_dead_cnt_nxt = '0;
          w_state_nxt    = i_ir_valid ? OwnIr : r_saved;
        end else begin
          w_dead_cnt_nxt = r_dead_cnt - OneC;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= OwnNone;
      r_saved    <= OwnNone;
      r_ir_cmd   <= CmdStop;
      r_vis_cmd  <= CmdStop;
      r_cnt      <= '0;
      r_dead_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_saved    <= w_saved_nxt;
      r_ir_cmd   <= w_ir_cmd_nxt;
      r_vis_cmd  <= w_vis_cmd_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dead_cnt <= w_dead_cnt_nxt;
    end
  end

  drive_cmd_arbiter_out_stage u_out_stage (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_target    (w_tgt),
    .i_ready     (i_out_ready),
    .o_valid     (o_out_valid),
    .o_cmd       (w_out_cmd),
    .o_last_sent (w_last_sent)
  );

  assign o_out_cmd = w_out_cmd;
  assign o_owner   = r_state;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Directed bench for drive_cmd_arbiter with short hold/timeout/dead-time values.
module tb_drive_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ir_valid = 1'b0;
  logic [2:0] ir_cmd = 3'd0;
  logic       vis_valid = 1'b0;
  logic [2:0] vis_cmd = 3'd0;
  logic       audio_arm = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [2:0] out_cmd;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  drive_cmd_arbiter #(
    .IR_HOLD     (20),
    .VIS_TIMEOUT (10),
    .DEADTIME    (4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_ir_valid  (ir_valid),
    .i_ir_cmd    (ir_cmd),
    .i_vis_valid (vis_valid),
    .i_vis_cmd   (vis_cmd),
    .i_audio_arm (audio_arm),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_out_cmd   (out_cmd),
    .o_owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ir_valid = 1'b0;
    vis_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic ir_strobe(input logic [2:0] c);
    ir_valid = 1'b1;
    ir_cmd = c;
    tick();
    ir_valid = 1'b0;
  endtask

  task automatic vis_strobe(input logic [2:0] c);
    vis_valid = 1'b1;
    vis_cmd = c;
    tick();
    vis_valid = 1'b0;
  endtask

  initial begin
    // Idle after reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_valid", 8'(out_valid), 8'd0);
    end
    chk("idle_cmd", 8'(out_cmd), 8'd0);
    chk("idle_owner", 8'(owner), 8'd0);

    // Vision ignored while disarmed
    vis_strobe(3'd3);
    chk("disarm_owner", 8'(owner), 8'd0);

    // Armed vision: 2-cycle latency, then Stop after the age timeout
    audio_arm = 1'b1;
    vis_strobe(3'd3);
    chk("vis_owner", 8'(owner), 8'd2);
    chk("vis_valid_e0", 8'(out_valid), 8'd0);
    tick();
    chk("vis_valid_e1", 8'(out_valid), 8'd1);
    chk("vis_cmd_e1", 8'(out_cmd), 8'd3);
    tick();
    chk("vis_accept", 8'(out_valid), 8'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("vis_hold_cmd", 8'(out_cmd), 8'd3);
    chk("vis_hold_valid", 8'(out_valid), 8'd0);
    tick();
    chk("vis_to_valid", 8'(out_valid), 8'd1);
    chk("vis_to_cmd", 8'(out_cmd), 8'd0);
    chk("vis_to_owner", 8'(owner), 8'd2);

    // Disarm drops vision ownership
    audio_arm = 1'b0;
    tick();
    chk("vis_disarm_owner", 8'(owner), 8'd0);

    // IR preempts vision with a reversal: dead time then Fast_right
    do_reset();
    audio_arm = 1'b1;
    vis_strobe(3'd2);
    tick();
    chk("pre_vis_cmd", 8'(out_cmd), 8'd2);
    tick();
    ir_valid = 1'b1;
    ir_cmd = 3'd5;
    vis_valid = 1'b1;
    vis_cmd = 3'd1;
    tick();
    ir_valid = 1'b0;
    vis_valid = 1'b0;
    chk("pre_owner", 8'(owner), 8'd1);
    tick();
    chk("dead_owner0", 8'(owner), 8'd3);
    chk("dead_stop_valid", 8'(out_valid), 8'd1);
    chk("dead_stop_cmd", 8'(out_cmd), 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dead_owner", 8'(owner), 8'd3);
      chk("dead_cmd", 8'(out_cmd), 8'd0);
    end
    tick();
    chk("post_dead_owner", 8'(owner), 8'd1);
    chk("post_dead_cmd", 8'(out_cmd), 8'd0);
    tick();
    chk("post_dead_valid", 8'(out_valid), 8'd1);
    chk("post_dead_fr", 8'(out_cmd), 8'd5);
    vis_strobe(3'd1);
    tick();
    tick();
    chk("vis_ignored_cmd", 8'(out_cmd), 8'd5);
    chk("vis_ignored_owner", 8'(owner), 8'd1);

    // IR hold expiry
    do_reset();
    ir_strobe(3'd3);
    chk("hold_owner0", 8'(owner), 8'd1);
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("hold_owner", 8'(owner), 8'd1);
    end
    chk("hold_cmd", 8'(out_cmd), 8'd3);
    tick();
    chk("hold_expired", 8'(owner), 8'd0);
    tick();
    chk("hold_stop_valid", 8'(out_valid), 8'd1);
    chk("hold_stop_cmd", 8'(out_cmd), 8'd0);

    // Backpressure: held command stable, latest target issued afterwards
    do_reset();
    out_ready = 1'b0;
    ir_strobe(3'd3);
    tick();
    chk("bp_valid", 8'(out_valid), 8'd1);
    chk("bp_cmd", 8'(out_cmd), 8'd3);
    ir_strobe(3'd4);
    tick();
    ir_strobe(3'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", 8'(out_valid), 8'd1);
      chk("bp_hold_cmd", 8'(out_cmd), 8'd3);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drop", 8'(out_valid), 8'd0);
    chk("bp_not_stale", 8'(out_cmd), 8'd3);
    tick();
    chk("bp_latest_valid", 8'(out_valid), 8'd1);
    chk("bp_latest_cmd", 8'(out_cmd), 8'd1);

    // Out-of-range code acts as Stop; async reset mid-handshake
    do_reset();
    ir_strobe(3'd3);
    tick();
    tick();
    ir_strobe(3'd7);
    chk("c7_owner", 8'(owner), 8'd1);
    tick();
    chk("c7_valid", 8'(out_valid), 8'd1);
    chk("c7_cmd", 8'(out_cmd), 8'd0);
    ir_strobe(3'd4);
    out_ready = 1'b0;
    tick();
    chk("rst_pre_valid", 8'(out_valid), 8'd1);
    chk("rst_pre_cmd", 8'(out_cmd), 8'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 8'(out_valid), 8'd0);
    chk("rst_async_cmd", 8'(out_cmd), 8'd0);
    chk("rst_async_owner", 8'(owner), 8'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rst_after_valid", 8'(out_valid), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
